// File: rtl/rriscv_pkg.sv
// Shared machine-width constants and requester identifiers for the data-memory
// port and its arbiter.
package rriscv_pkg;

    localparam int XLEN          = 32;
    localparam int DATA_MEM_SIZE = 1024;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } req_id_t;

    // Word addresses are unsigned and compared against a word count.
    function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                           input logic [XLEN-1:0] limit);
        return addr < limit;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester that did not win last
// time is granted; a lone request is granted immediately.
module rr_arb2
    import rriscv_pkg::*;
(
    input  logic [1:0] req_i,   // bit 0 core, bit 1 DMA
    input  req_id_t    last_i,
    output logic [1:0] gnt_o    // one-hot or zero
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = (last_i == REQ_DMA) ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read data memory between the core and the DMA engine,
// one request per cycle, with a response strobe one cycle after each grant.
module mem_arbiter
    import rriscv_pkg::*;
#(
    parameter int ADDR_LIMIT = DATA_MEM_SIZE
) (
    input  logic            clk_i,
    input  logic            rst_n_i,

    // valid/ready: a request transfers on a rising edge where valid_i && ready_o;
    // ready_o may depend on valid_i, the requester holds its payload until ready_o.
    input  logic            c_valid_i,
    output logic            c_ready_o,
    input  logic            c_we_i,
    input  logic [XLEN-1:0] c_addr_i,
    input  logic [XLEN-1:0] c_wdata_i,
    output logic            c_rsp_valid_o,
    output logic            c_rsp_err_o,
    output logic [XLEN-1:0] c_rsp_rdata_o,

    input  logic            d_valid_i,
    output logic            d_ready_o,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    output logic            d_rsp_valid_o,
    output logic            d_rsp_err_o,
    output logic [XLEN-1:0] d_rsp_rdata_o,

    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,

    output logic            dbg_state_o     // 1 while a response is being returned
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    localparam logic [XLEN-1:0] LIMIT = XLEN'(ADDR_LIMIT);

    state_t          state_q, state_d;
    req_id_t         last_q, last_d;
    req_id_t         owner_q, owner_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            accept;
    req_id_t         sel_id;
    logic            sel_we;
    logic            sel_legal;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic            rsp_active;
    logic [XLEN-1:0] rsp_rdata;

    // No grants while reset is held so every memory-side output reads zero.
    assign req = {d_valid_i, c_valid_i} & {2{rst_n_i}};

    rr_arb2 u_rr_arb2 (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    assign c_ready_o = gnt[0];
    assign d_ready_o = gnt[1];
    assign accept    = |gnt;

    always_comb begin
        sel_id    = gnt[1] ? REQ_DMA   : REQ_CORE;
        sel_we    = gnt[1] ? d_we_i    : c_we_i;
        sel_addr  = gnt[1] ? d_addr_i  : c_addr_i;
        sel_wdata = gnt[1] ? d_wdata_i : c_wdata_i;
        sel_legal = addr_in_range(sel_addr, LIMIT);
    end

    // Memory bus follows a legal grant combinationally and otherwise holds.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept && sel_legal) begin
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
        end
    end

    assign mem_we_o    = accept && sel_legal && sel_we;
    assign mem_addr_o  = addr_d;
    assign mem_wdata_o = wdata_d;

    always_comb begin
        state_d = accept ? S_RESP : S_IDLE;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        err_d   = err_q;
        if (accept) begin
            last_d  = sel_id;
            owner_d = sel_id;
            we_d    = sel_we;
            err_d   = !sel_legal;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            last_q  <= REQ_DMA;
            owner_q <= REQ_CORE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Writes and rejected requests return zero data; reads pass the memory through.
    assign rsp_active = (state_q == S_RESP);
    assign rsp_rdata  = (we_q || err_q) ? '0 : mem_rdata_i;

    assign c_rsp_valid_o = rsp_active && (owner_q == REQ_CORE);
    assign c_rsp_err_o   = c_rsp_valid_o && err_q;
    assign c_rsp_rdata_o = c_rsp_valid_o ? rsp_rdata : '0;

    assign d_rsp_valid_o = rsp_active && (owner_q == REQ_DMA);
    assign d_rsp_err_o   = d_rsp_valid_o && err_q;
    assign d_rsp_rdata_o = d_rsp_valid_o ? rsp_rdata : '0;

    assign dbg_state_o = rsp_active;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a registered-read memory model.
module tb_mem_arbiter;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          c_valid_i, c_we_i, d_valid_i, d_we_i;
    logic [W-1:0]  c_addr_i, c_wdata_i, d_addr_i, d_wdata_i;
    logic          c_ready_o, d_ready_o;
    logic          c_rsp_valid_o, c_rsp_err_o, d_rsp_valid_o, d_rsp_err_o;
    logic [W-1:0]  c_rsp_rdata_o, d_rsp_rdata_o;
    logic          mem_we_o;
    logic [W-1:0]  mem_addr_o, mem_wdata_o;
    logic [W-1:0]  mem_rdata_i;
    logic          dbg_state_o;

    logic          init_mem;
    logic [W-1:0]  mem_model [1024];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .c_valid_i     (c_valid_i),
        .c_ready_o     (c_ready_o),
        .c_we_i        (c_we_i),
        .c_addr_i      (c_addr_i),
        .c_wdata_i     (c_wdata_i),
        .c_rsp_valid_o (c_rsp_valid_o),
        .c_rsp_err_o   (c_rsp_err_o),
        .c_rsp_rdata_o (c_rsp_rdata_o),
        .d_valid_i     (d_valid_i),
        .d_ready_o     (d_ready_o),
        .d_we_i        (d_we_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_rsp_valid_o (d_rsp_valid_o),
        .d_rsp_err_o   (d_rsp_err_o),
        .d_rsp_rdata_o (d_rsp_rdata_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .dbg_state_o   (dbg_state_o)
    );

    // Registered-read memory: read data reflects contents before this edge's write.
    always @(posedge clk_i) begin
        if (init_mem) begin
            mem_model[0] <= 32'h0000_00A0;
            mem_model[3] <= 32'h0000_0033;
            mem_model[5] <= 32'hDEAD_BEEF;
            mem_model[6] <= 32'h0000_0066;
            mem_model[7] <= 32'h0000_0077;
            mem_model[8] <= 32'h0000_0088;
            mem_model[9] <= 32'h0000_0099;
        end else if (mem_we_o) begin
            mem_model[mem_addr_o[9:0]] <= mem_wdata_o;
        end
        mem_rdata_i <= mem_model[mem_addr_o[9:0]];
    end

    typedef struct {
        logic         cv, cwe;
        logic [W-1:0] caddr, cwd;
        logic         dv, dwe;
        logic [W-1:0] daddr, dwd;
        logic         e_cr, e_dr, e_mwe, chk_addr;
        logic [W-1:0] e_maddr;
        logic         e_cv, e_ce;
        logic [W-1:0] e_cd;
        logic         e_dv, e_de;
        logic [W-1:0] e_dd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cv, input logic cwe, input logic [W-1:0] caddr,
                       input logic [W-1:0] cwd, input logic dv, input logic dwe,
                       input logic [W-1:0] daddr, input logic [W-1:0] dwd,
                       input logic e_cr, input logic e_dr, input logic e_mwe,
                       input logic chk_addr, input logic [W-1:0] e_maddr,
                       input logic e_cv, input logic e_ce, input logic [W-1:0] e_cd,
                       input logic e_dv, input logic e_de, input logic [W-1:0] e_dd);
        vec_t v;
        v.cv = cv; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dv = dv; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.e_cr = e_cr; v.e_dr = e_dr; v.e_mwe = e_mwe; v.chk_addr = chk_addr;
        v.e_maddr = e_maddr;
        v.e_cv = e_cv; v.e_ce = e_ce; v.e_cd = e_cd;
        v.e_dv = e_dv; v.e_de = e_de; v.e_dd = e_dd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        c_valid_i = 1'b0; c_we_i = 1'b0; c_addr_i = '0; c_wdata_i = '0;
        d_valid_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " c_rsp_valid"}, W'(c_rsp_valid_o), 0);
        chk({tag, " c_rsp_err"},   W'(c_rsp_err_o),   0);
        chk({tag, " c_rsp_rdata"}, c_rsp_rdata_o,     0);
        chk({tag, " d_rsp_valid"}, W'(d_rsp_valid_o), 0);
        chk({tag, " d_rsp_err"},   W'(d_rsp_err_o),   0);
        chk({tag, " d_rsp_rdata"}, d_rsp_rdata_o,     0);
        chk({tag, " mem_we"},      W'(mem_we_o),      0);
        chk({tag, " mem_addr"},    mem_addr_o,        0);
        chk({tag, " mem_wdata"},   mem_wdata_o,       0);
    endtask

    // Called at a falling edge: drive, check request side, clock, check response side.
    task automatic apply(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        c_valid_i = v.cv; c_we_i = v.cwe; c_addr_i = v.caddr; c_wdata_i = v.cwd;
        d_valid_i = v.dv; d_we_i = v.dwe; d_addr_i = v.daddr; d_wdata_i = v.dwd;
        #1;
        chk({t, " c_ready"}, W'(c_ready_o), W'(v.e_cr));
        chk({t, " d_ready"}, W'(d_ready_o), W'(v.e_dr));
        chk({t, " mem_we"},  W'(mem_we_o),  W'(v.e_mwe));
        if (v.chk_addr) chk({t, " mem_addr"}, mem_addr_o, v.e_maddr);
        if (v.e_mwe) chk({t, " mem_wdata"}, mem_wdata_o, v.e_cr ? v.cwd : v.dwd);
        @(posedge clk_i);
        @(negedge clk_i);
        chk({t, " c_rsp_valid"}, W'(c_rsp_valid_o), W'(v.e_cv));
        chk({t, " c_rsp_err"},   W'(c_rsp_err_o),   W'(v.e_ce));
        chk({t, " c_rsp_rdata"}, c_rsp_rdata_o,     v.e_cd);
        chk({t, " d_rsp_valid"}, W'(d_rsp_valid_o), W'(v.e_dv));
        chk({t, " d_rsp_err"},   W'(d_rsp_err_o),   W'(v.e_de));
        chk({t, " d_rsp_rdata"}, d_rsp_rdata_o,     v.e_dd);
    endtask

    // Reset asserted in the cycle after an acceptance by the chosen requester.
    task automatic mid_reset(input logic use_dma);
        string t;
        t = use_dma ? "rst_dma" : "rst_core";
        idle_inputs();
        if (use_dma) begin
            d_valid_i = 1'b1; d_addr_i = 32'd6;
        end else begin
            c_valid_i = 1'b1; c_addr_i = 32'd5;
        end
        #1;
        chk({t, " ready"}, W'(use_dma ? d_ready_o : c_ready_o), 1);
        @(posedge clk_i);
        @(negedge clk_i);
        idle_inputs();
        chk({t, " pre rsp_valid"}, W'(use_dma ? d_rsp_valid_o : c_rsp_valid_o), 1);
        rst_n_i = 1'b0;
        #1;
        check_all_zero({t, " during"});
        chk({t, " dbg_state"}, W'(dbg_state_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk({t, " after c_rsp_valid"}, W'(c_rsp_valid_o), 0);
            chk({t, " after d_rsp_valid"}, W'(d_rsp_valid_o), 0);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        c_valid_i = 1'b1; c_addr_i = 32'd7;
        d_valid_i = 1'b1; d_addr_i = 32'd8;
        #1;
        chk({t, " contend c_ready"}, W'(c_ready_o), 1);
        chk({t, " contend d_ready"}, W'(d_ready_o), 0);
        chk({t, " contend mem_addr"}, mem_addr_o, 32'd7);
        @(posedge clk_i);
        @(negedge clk_i);
        idle_inputs();
        chk({t, " contend c_rsp_valid"}, W'(c_rsp_valid_o), 1);
        chk({t, " contend c_rsp_rdata"}, c_rsp_rdata_o, 32'h77);
        chk({t, " contend d_rsp_valid"}, W'(d_rsp_valid_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        //  cv cwe caddr       cwd       dv dwe daddr  dwd      cr dr mwe ca maddr  cv ce cd            dv de dd
        add(1, 0, 32'd5,    32'h0,   1, 0, 32'd6, 32'h0,   1, 0, 0, 1, 32'd5,  1, 0, 32'hDEADBEEF, 0, 0, 32'h0);
        add(1, 0, 32'd7,    32'h0,   1, 0, 32'd6, 32'h0,   0, 1, 0, 1, 32'd6,  0, 0, 32'h0,        1, 0, 32'h66);
        add(1, 0, 32'd7,    32'h0,   1, 0, 32'd8, 32'h0,   1, 0, 0, 1, 32'd7,  1, 0, 32'h77,       0, 0, 32'h0);
        add(1, 0, 32'd9,    32'h0,   1, 0, 32'd8, 32'h0,   0, 1, 0, 1, 32'd8,  0, 0, 32'h0,        1, 0, 32'h88);
        add(0, 0, 32'd0,    32'h0,   0, 0, 32'd0, 32'h0,   0, 0, 0, 1, 32'd8,  0, 0, 32'h0,        0, 0, 32'h0);
        add(1, 0, 32'd5,    32'h0,   0, 0, 32'd0, 32'h0,   1, 0, 0, 1, 32'd5,  1, 0, 32'hDEADBEEF, 0, 0, 32'h0);
        add(0, 0, 32'd0,    32'h0,   1, 1, 32'd3, 32'h12,  0, 1, 1, 1, 32'd3,  0, 0, 32'h0,        1, 0, 32'h0);
        add(1, 0, 32'd3,    32'h0,   0, 0, 32'd0, 32'h0,   1, 0, 0, 1, 32'd3,  1, 0, 32'h12,       0, 0, 32'h0);
        add(1, 0, 32'd3,    32'h0,   1, 1, 32'd3, 32'h45,  0, 1, 1, 1, 32'd3,  0, 0, 32'h0,        1, 0, 32'h0);
        add(1, 0, 32'd3,    32'h0,   0, 0, 32'd0, 32'h0,   1, 0, 0, 1, 32'd3,  1, 0, 32'h45,       0, 0, 32'h0);
        add(1, 1, 32'd1024, 32'hBAD, 0, 0, 32'd0, 32'h0,   1, 0, 0, 0, 32'd0,  1, 1, 32'h0,        0, 0, 32'h0);
        add(0, 0, 32'd0,    32'h0,   1, 0, 32'd0, 32'h0,   0, 1, 0, 1, 32'd0,  0, 0, 32'h0,        1, 0, 32'hA0);
        add(0, 0, 32'd0,    32'h0,   1, 0, 32'd2000, 32'h0, 0, 1, 0, 0, 32'd0, 0, 0, 32'h0,        1, 1, 32'h0);
        add(1, 1, 32'd9,    32'h5A,  1, 0, 32'd9, 32'h0,   1, 0, 1, 1, 32'd9,  1, 0, 32'h0,        0, 0, 32'h0);
        add(0, 0, 32'd0,    32'h0,   1, 0, 32'd9, 32'h0,   0, 1, 0, 1, 32'd9,  0, 0, 32'h0,        1, 0, 32'h5A);
        add(0, 0, 32'd0,    32'h0,   0, 0, 32'd0, 32'h0,   0, 0, 0, 1, 32'd9,  0, 0, 32'h0,        0, 0, 32'h0);

        rst_n_i  = 1'b0;
        init_mem = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        chk("reset c_ready", W'(c_ready_o), 0);
        chk("reset d_ready", W'(d_ready_o), 0);
        chk("reset dbg_state", W'(dbg_state_o), 0);
        rst_n_i  = 1'b1;
        init_mem = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end
        idle_inputs();

        mid_reset(1'b1);
        mid_reset(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
